// File: rtl/segdisp_pkg.sv
// Shared constants for the seven-segment scan controller: hex font, digit count
// and the idle drive levels for both board polarities.
package segdisp_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-high {g,f,e,d,c,b,a} patterns for 0..F.
    localparam logic [6:0] HEX_FONT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0]            SEG_OFF_AL = 7'h7F;
    localparam logic [6:0]            SEG_OFF_AH = 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_AL = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_AH = 8'h00;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } slot_phase_e;

endpackage

// File: rtl/segdisp_scan_ctrl_if.sv
// Display-word write port and multiplexed display drive of the scan controller.
interface segdisp_scan_ctrl_if;

    logic        enable;
    logic [31:0] wr_data;
    logic        wr_strobe;
    logic [6:0]  seg;
    logic [7:0]  digit;
    logic        frame_tick;
    logic        pending;

    modport master (
        output enable, wr_data, wr_strobe,
        input  seg, digit, frame_tick, pending
    );

    modport slave (
        input  enable, wr_data, wr_strobe,
        output seg, digit, frame_tick, pending
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7
    import segdisp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/segdisp_scan_ctrl.sv
// Eight-digit seven-segment scan controller with per-slot blanking and a
// frame-synchronous double buffer for the display word.
module segdisp_scan_ctrl
    import segdisp_pkg::*;
#(
    parameter int DIV        = 50000,
    parameter int BLANK      = 500,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    segdisp_scan_ctrl_if.slave bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? DIG_OFF_AL : DIG_OFF_AH;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [31:0]           staged;
    logic [31:0]           shadow;
    logic                  pending;
    logic                  frame_tick;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] digit_q;

    logic                  slot_end;
    logic                  boundary;
    slot_phase_e           phase;
    logic                  lit;
    logic [3:0]            nib;
    logic [6:0]            font_seg;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] digit_d;

    hex_to_seg7 u_font (
        .nibble (nib),
        .seg    (font_seg)
    );

    always_comb begin
        slot_end = bus.enable && (cnt == CW'(DIV - 1));
        boundary = slot_end && (idx == IW'(NUM_DIGITS - 1));
        phase    = (cnt >= CW'(BLANK)) ? PH_ON : PH_BLANK;
        lit      = bus.enable && (phase == PH_ON);
        nib      = shadow[{idx, 2'b00} +: 4];
        seg_d    = SEG_OFF;
        digit_d  = DIG_OFF;
        if (lit) begin
            // XOR with the idle level flips the active-high pattern for common-anode boards.
            seg_d   = font_seg ^ SEG_OFF;
            digit_d = (NUM_DIGITS'(1) << idx) ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            staged     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            seg_q      <= SEG_OFF;
            digit_q    <= DIG_OFF;
        end else begin
            if (bus.wr_strobe)
                staged <= bus.wr_data;
            // A write landing on the boundary keeps pending set for the following frame.
            pending    <= bus.wr_strobe | (pending & ~boundary);
            if (boundary && pending)
                shadow <= staged;
            frame_tick <= boundary;
            if (bus.enable) begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            seg_q   <= seg_d;
            digit_q <= digit_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.digit      = digit_q;
    assign bus.frame_tick = frame_tick;
    assign bus.pending    = pending;

endmodule
